// File: rtl/test_stim_pkg.sv
// test_stim_pkg: FSM states, pattern mode encodings and PRBS7 (x^7 + x^6 + 1) taps, seed and step function
package test_stim_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [1:0] MODE_ZERO = 2'd0;
  localparam logic [1:0] MODE_TOGGLE = 2'd1;
  localparam logic [1:0] MODE_PRBS = 2'd2;
  localparam logic [1:0] MODE_ONE = 2'd3;
  localparam int PRBS_TAP_A = 6;
  localparam int PRBS_TAP_B = 5;
  localparam logic [6:0] PRBS_DEFAULT_SEED = 7'h7F;
  function automatic logic [6:0] prbs_step(input logic [6:0] s);
    return {s[5:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction
endpackage

// File: rtl/prbs7_gen.sv
// prbs7_gen: PRBS7 LFSR (clk, rst, load seed, advance one step, bit_o = lfsr[6])
module prbs7_gen import test_stim_pkg::*; #(
  parameter logic [6:0] SEED = PRBS_DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       advance,
  output logic       bit_o
);
  logic [6:0] lfsr;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= SEED;
    else if (load) lfsr <= seed;
    else if (advance) lfsr <= prbs_step(lfsr);
  assign bit_o = lfsr[PRBS_TAP_A];
endmodule

// File: rtl/test_stim.sv
// test_stim: drives toggle_change with a mode-selected pattern for run_len cycles, drains, counts data_i transitions (busy/done/act_count); the LFSR is loaded one step ahead because toggle_change is registered
module test_stim import test_stim_pkg::*; #(
  parameter int         CNT_W     = 16,
  parameter int         DRAIN_CYC = 16,
  parameter logic [6:0] PRBS_SEED = 7'h7F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] run_len,
  input  logic             data_i,
  output logic             toggle_change,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] act_count
);
  localparam int DW = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYC - 1);
  state_t state, state_nxt;
  logic [1:0] mode_q;
  logic [CNT_W-1:0] run_cnt;
  logic [DW-1:0] drain_cnt;
  logic hist, prbs_bit, accept, run_last, drain_last, first_bit, step_bit, nxt_bit, to_drain;
  assign accept = state == IDLE && start;
  assign run_last = run_cnt == '0;
  assign drain_last = drain_cnt == '0;
  assign to_drain = (accept && run_len == '0) || (state == RUN && run_last);
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign first_bit = mode == MODE_PRBS ? PRBS_SEED[PRBS_TAP_A] : mode != MODE_ZERO;
  assign step_bit = mode_q == MODE_PRBS ? prbs_bit : mode_q == MODE_TOGGLE ? ~toggle_change : mode_q == MODE_ONE;
  assign nxt_bit = accept ? run_len != '0 && first_bit : state == RUN && !run_last && step_bit;
  prbs7_gen #(.SEED(PRBS_SEED)) u_prbs (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .seed(prbs_step(PRBS_SEED)),
    .advance(state == RUN),
    .bit_o(prbs_bit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (start ? (run_len != '0 ? RUN : DRAIN) : IDLE)
              : state == RUN ? (run_last ? DRAIN : RUN)
              : state == DRAIN ? (drain_last ? DONE : DRAIN)
              : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      toggle_change <= 1'b0;
      mode_q <= MODE_ZERO;
      run_cnt <= '0;
      drain_cnt <= '0;
      hist <= 1'b0;
      act_count <= '0;
    end else begin
      toggle_change <= nxt_bit;
      hist <= data_i;
      if (accept) begin
        mode_q <= mode;
        run_cnt <= run_len - 1'b1;
      end else if (state == RUN && !run_last) run_cnt <= run_cnt - 1'b1;
      if (to_drain) drain_cnt <= DRAIN_INIT;
      else if (state == DRAIN) drain_cnt <= drain_cnt - 1'b1;
      if (accept) act_count <= '0;
      else if (busy && data_i != hist && act_count != '1) act_count <= act_count + 1'b1;
    end
endmodule

// File: tb/tb_test_stim.sv
// tb_test_stim: table-driven and hand-sequenced checks of test_stim (CNT_W=16 and CNT_W=4 instances)
module tb_test_stim;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, lb = 1'b0, dforce = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [15:0] run_len = 16'd0;
  logic data_i, tc, busy, done;
  logic [15:0] act;
  logic start4 = 1'b0, d4 = 1'b0, tc4, busy4, done4;
  logic [1:0] mode4 = 2'd0;
  logic [3:0] len4 = 4'd0, act4;
  int total = 0, bad = 0;
  logic prbs_ref [0:126];
  logic seq [0:255];
  logic first_prbs [0:126];
  typedef struct {logic [1:0] m; int len; logic lb; logic dv; int lat; int bsy; int act; int ones;} vec_t;
  vec_t v [6];
  always #5 clk = ~clk;
  assign data_i = lb ? tc : dforce;
  test_stim dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .run_len(run_len), .data_i(data_i),
    .toggle_change(tc), .busy(busy), .done(done), .act_count(act)
  );
  test_stim #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .run_len(len4), .data_i(d4),
    .toggle_change(tc4), .busy(busy4), .done(done4), .act_count(act4)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  function automatic logic exp_bit(input logic [1:0] m, input int k);
    return m == 2'd0 ? 1'b0 : m == 2'd1 ? (k % 2 == 0) : m == 2'd2 ? prbs_ref[k % 127] : 1'b1;
  endfunction
  task automatic wait_done(input int c0, output int lat);
    lat = -1;
    for (int c = c0; c < c0 + 400; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      step();
    end
  endtask
  task automatic run(input logic [1:0] m, input int len, output int lat, output int bc, output int ones, output int pm, output int ex);
    mode = m;
    run_len = 16'(len);
    start = 1'b1;
    step();
    start = 1'b0;
    mode = ~m;
    run_len = 16'd5;
    lat = -1; bc = 0; ones = 0; pm = 0; ex = 0;
    for (int c = 1; c < 400; c++) begin
      if (busy) bc++;
      if (c <= len) begin
        seq[(c - 1) % 256] = tc;
        ones += int'(tc);
        if (tc != exp_bit(m, c - 1)) pm++;
      end else ex += int'(tc);
      if (done) begin
        lat = c;
        break;
      end
      step();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, bc, ones, pm, ex, dcnt;
    logic [6:0] r;
    r = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      prbs_ref[i] = r[6];
      r = {r[5:0], r[6] ^ r[5]};
    end
    v[0] = '{2'd1, 8, 1'b1, 1'b0, 25, 24, 8, 4};
    v[1] = '{2'd2, 127, 1'b1, 1'b0, 144, 143, 64, 64};
    v[2] = '{2'd3, 0, 1'b0, 1'b0, 17, 16, 0, 0};
    v[3] = '{2'd3, 5, 1'b1, 1'b0, 22, 21, 2, 5};
    v[4] = '{2'd0, 3, 1'b0, 1'b1, 20, 19, 0, 0};
    v[5] = '{2'd1, 1, 1'b1, 1'b0, 18, 17, 2, 1};
    repeat (2) step();
    check("rst_tc", tc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_act", act, 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      lb = v[i].lb;
      dforce = v[i].dv;
      run(v[i].m, v[i].len, lat, bc, ones, pm, ex);
      check($sformatf("v%0d_latency", i), lat, v[i].lat);
      check($sformatf("v%0d_busy_cycles", i), bc, v[i].bsy);
      check($sformatf("v%0d_act_count", i), act, v[i].act);
      check($sformatf("v%0d_ones", i), ones, v[i].ones);
      check($sformatf("v%0d_pattern_errors", i), pm, 0);
      check($sformatf("v%0d_ones_outside_run", i), ex, 0);
      if (i == 1) for (int k = 0; k < 127; k++) first_prbs[k] = seq[k];
      step();
    end
    dforce = 1'b0;
    repeat (3) step();
    check("act_held_in_idle", act, 2);
    pm = 0;
    for (int k = 0; k < 7; k++) pm += int'(first_prbs[k]);
    check("prbs_first7_ones", pm, 7);
    check("prbs_bit8", first_prbs[7], 0);
    lb = 1'b1;
    run(2'd2, 127, lat, bc, ones, pm, ex);
    pm = 0;
    for (int k = 0; k < 127; k++) pm += int'(seq[k] != first_prbs[k]);
    check("prbs_repeat_diff", pm, 0);
    check("prbs_repeat_ones", ones, 64);
    step();
    mode = 2'd1;
    run_len = 16'd100;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    check("pre_rst_busy", busy, 1);
    check("pre_rst_tc", tc, 1);
    check("pre_rst_act", act, 40);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_tc", tc, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_act", act, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    dcnt = 0;
    repeat (150) begin
      step();
      dcnt += int'(done);
    end
    check("no_done_after_rst", dcnt, 0);
    run(2'd1, 8, lat, bc, ones, pm, ex);
    check("after_rst_latency", lat, 25);
    check("after_rst_act", act, 8);
    check("after_rst_pattern", pm, 0);
    step();
    mode = 2'd1;
    run_len = 16'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    start = 1'b1;
    mode = 2'd3;
    run_len = 16'd2;
    step();
    start = 1'b0;
    check("start_in_run_tc", tc, 0);
    check("start_in_run_busy", busy, 1);
    wait_done(4, lat);
    check("start_in_run_latency", lat, 27);
    start = 1'b1;
    mode = 2'd1;
    run_len = 16'd4;
    step();
    check("start_in_done_busy", busy, 0);
    check("start_in_done_done", done, 0);
    step();
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_tc", tc, 1);
    wait_done(1, lat);
    check("restart_latency", lat, 21);
    step();
    mode4 = 2'd1;
    len4 = 4'd15;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    lat = -1;
    for (int c = 1; c < 100; c++) begin
      d4 = c <= 15 ? tc4 : ~d4;
      if (c == 18) check("sat_mid_act", act4, 15);
      if (done4) begin
        lat = c;
        break;
      end
      step();
    end
    check("sat_latency", lat, 32);
    check("sat_final_act", act4, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/test_stim.md
Name: test_stim

Overview:
- Stimulus and monitor block for the `toggle_change`/`data_o` test-unit interface.
- Drives the serial `toggle_change` input of a test unit with a selectable pattern for a programmed number of cycles.
- Waits a drain window so the unit's pipeline and RAM latency flush, then counts transitions seen on the unit's `data_o` during the whole run.
- Sits beside each test-unit instance in resource and power-characterisation builds.

Parameters:
- CNT_W, 16, width of the run-length counter and the activity counter.
- DRAIN_CYC, 16, cycles spent in DRAIN after RUN; must cover the test unit's input-to-`data_o` latency; minimum 1.
- PRBS_SEED, 7'h7F, PRBS7 seed loaded at start; a non-zero value is required.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- mode  in  2  pattern select: 0 = constant 0, 1 = toggle every cycle, 2 = PRBS7, 3 = constant 1.
- run_len  in  CNT_W  number of stimulus cycles.
- data_i  in  1  connects to the test unit's `data_o`.
- toggle_change  out  1  registered stimulus to the test unit.
- busy  out  1  high from the first RUN cycle until the last DRAIN cycle.
- done  out  1  single-cycle pulse at run completion.
- act_count  out  CNT_W  number of `data_i` transitions in the last run.

Behaviour:
- Reset (async, `rst` = 1):
  - state = IDLE.
  - `toggle_change`, `busy`, `done` = 0; `act_count` = 0.
  - LFSR = PRBS_SEED; run counter, drain counter and `data_i` history register = 0.
  - Reset mid-run abandons the run; no `done` pulse is produced.
- State machine IDLE -> RUN -> DRAIN -> DONE -> IDLE:
  - IDLE:
    - `start` = 1 latches `mode` and `run_len`, clears `act_count`, reloads the LFSR with PRBS_SEED.
    - Next state is RUN if the latched `run_len` != 0, else DRAIN.
  - RUN:
    - Lasts exactly `run_len` cycles.
    - `toggle_change` takes the pattern value in each of those cycles.
    - The first RUN cycle is the cycle immediately after `start` was sampled.
  - DRAIN:
    - Lasts exactly DRAIN_CYC cycles.
    - `toggle_change` = 0.
  - DONE:
    - Lasts 1 cycle; `done` = 1, `busy` = 0.
    - Returns to IDLE.
    - `start` is ignored in DONE; the earliest accepted restart is the following cycle.
- `start` in RUN, DRAIN or DONE is ignored. Input changes to `mode` and `run_len` after latching have no effect.
- Patterns, registered so they are valid in the RUN cycles:
  - mode 1: first RUN value is 1, then alternates 0, 1, 0, ...
  - mode 2: PRBS7, polynomial x^7 + x^6 + 1.
    - Output = lfsr[6].
    - Next state = {lfsr[5:0], lfsr[6]^lfsr[5]}.
    - The LFSR advances once per RUN cycle.
    - Period is 127.
  - Outside RUN, `toggle_change` = 0 for every mode.
- Activity monitor:
  - `data_i` is registered every cycle into a history register.
  - A transition is counted when `data_i` differs from the history register while state is RUN or DRAIN.
  - `act_count` saturates at 2^CNT_W - 1; no wrap.
  - `act_count` is held from DONE until the next accepted `start`.
- Counters:
  - Run counter loads `run_len` - 1 and decrements to 0; a `run_len` of all ones is supported with no overflow.
  - Drain counter loads DRAIN_CYC - 1 and decrements to 0.
- Latency: `done` asserts exactly 1 + `run_len` + DRAIN_CYC cycles after the cycle in which `start` was sampled.

Decomposition:
- Package test_stim_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE).
  - mode encodings (MODE_ZERO, MODE_TOGGLE, MODE_PRBS, MODE_ONE).
  - PRBS7 tap positions and default seed.
- Sub-module prbs7_gen:
  - Ports: clk, rst, load, seed, advance, bit_o.
  - Instantiated once.
  - The state machine, counters and monitor stay in test_stim.

Test Plan:
1. Reset asserted mid-RUN (mode 1, run_len = 100, at cycle 40) -> `toggle_change`, `busy`, `done`, `act_count` all 0 within the same cycle; no `done` pulse afterwards; a new `start` then runs normally.
2. mode 1, run_len = 8, DRAIN_CYC = 16, `data_i` looped from `toggle_change` -> `toggle_change` = 1,0,1,0,1,0,1,0 in cycles 1..8; `done` at cycle 25; `act_count` = 8.
3. mode 2, run_len = 127, seed 7'h7F -> first 7 bits are 1, 8th bit is 0; exactly 64 ones over 127 bits; a second run reproduces an identical sequence.
4. mode 3, run_len = 0 -> no RUN cycles; `toggle_change` stays 0; `busy` high for 16 cycles; `done` at cycle 17; `act_count` = 0 with `data_i` held at 0.
5. `start` pulsed during RUN and during DONE -> ignored, no restart; a pulse in the cycle after DONE is accepted.
6. CNT_W = 4, mode 1 loopback, run_len = 15 with `data_i` forced to toggle every cycle through DRAIN -> `act_count` saturates at 15, no wrap.
